// File: rtl/io_uart_responder.sv
// Memory-mapped 8N1 serial port on the CPU I/O bus: TX holding/shift path,
// RX with 2-flop synchroniser, sticky error flags and a programmable bit divisor.
module io_uart_responder #(
    parameter logic [1:0] SUB_SEL   = 2'b01,
    parameter logic [7:0] DIV_RESET = 8'd16
) (
    input  logic        clk,
    input  logic        rst_bar,
    input  logic [11:0] io_address,
    input  logic        cs_bar,
    input  logic        we_bar,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic        rxd,
    output logic        txd
);

    localparam int unsigned DW = 8;
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_RXDATA = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    // Bus decode
    logic       sel;
    logic       wr;
    logic       rd;
    logic [1:0] reg_sel;
    logic       wr_tx;
    logic       wr_div;
    logic       rd_status;
    logic       rd_rx;

    assign sel       = (io_address[11:4] == 8'hFF) && (io_address[3:2] == SUB_SEL) && !cs_bar;
    assign reg_sel   = io_address[1:0];
    assign wr        = sel && !we_bar;
    assign rd        = sel && we_bar;
    assign wr_tx     = wr && (reg_sel == REG_TXDATA);
    assign wr_div    = wr && (reg_sel == REG_DIV);
    assign rd_status = rd && (reg_sel == REG_STATUS);
    assign rd_rx     = rd && (reg_sel == REG_RXDATA);

    logic [DW-1:0] div_q, div_d;

    always_comb begin
        div_d = div_q;
        if (wr_div) begin
            div_d = (data_in < DW'(2)) ? DW'(2) : data_in;
        end
    end

    // ---------------- TX path ----------------
    tx_state_e     tx_state_q, tx_state_d;
    logic [DW-1:0] tx_cnt_q, tx_cnt_d;
    logic [DW-1:0] tx_per_q, tx_per_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [DW-1:0] tx_shift_q, tx_shift_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          tx_drop_q, tx_drop_d;
    logic          txd_q, txd_d;
    logic          tx_tick;
    logic          tx_load;

    assign tx_tick = (tx_cnt_q == (tx_per_q - DW'(1)));

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_per_d    = tx_per_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_load     = 1'b0;
        txd_d       = 1'b1;

        case (tx_state_q)
            TX_IDLE: begin
                if (hold_full_q) begin
                    tx_load = 1'b1;
                end
            end
            TX_START: begin
                txd_d = 1'b0;
                if (tx_tick) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = 3'd0;
                    tx_cnt_d   = '0;
                    tx_per_d   = div_q;
                end else begin
                    tx_cnt_d = tx_cnt_q + DW'(1);
                end
            end
            TX_DATA: begin
                txd_d = tx_shift_q[0];
                if (tx_tick) begin
                    tx_shift_d = {1'b0, tx_shift_q[DW-1:1]};
                    tx_cnt_d   = '0;
                    tx_per_d   = div_q;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + DW'(1);
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    if (hold_full_q) begin
                        tx_load = 1'b1;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + DW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // Holding register feeds the shifter; back-to-back frames have no idle gap
        if (tx_load) begin
            tx_state_d  = TX_START;
            tx_shift_d  = hold_q;
            hold_full_d = 1'b0;
            tx_cnt_d    = '0;
            tx_per_d    = div_q;
        end

        if (wr_tx && !hold_full_q) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        tx_drop_d = (tx_drop_q && !rd_status) || (wr_tx && hold_full_q);
    end

    // ---------------- RX path ----------------
    logic          sync1_q;
    logic          sync2_q;
    rx_state_e     rx_state_q, rx_state_d;
    logic [DW-1:0] rx_cnt_q, rx_cnt_d;
    logic [DW-1:0] rx_per_q, rx_per_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [DW-1:0] rx_shift_q, rx_shift_d;
    logic [DW-1:0] rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_ovr_q, rx_ovr_d;
    logic          frame_err_q, frame_err_d;
    logic          rx_tick;
    logic          rx_half_tick;
    logic          rx_done;
    logic          rx_fe_set;
    logic          rx_pop;

    assign rx_tick      = (rx_cnt_q == (rx_per_q - DW'(1)));
    assign rx_half_tick = (rx_cnt_q == ((rx_per_q >> 1) - DW'(1)));
    assign rx_pop       = rd_rx && rx_valid_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_per_d   = rx_per_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        rx_fe_set  = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                if (!sync2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                    rx_per_d   = div_q;
                end
            end
            RX_START: begin
                // Mid-start-bit sample rejects short glitches
                if (rx_half_tick) begin
                    if (sync2_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_bit_d   = 3'd0;
                        rx_cnt_d   = '0;
                        rx_per_d   = div_q;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + DW'(1);
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_shift_d = {sync2_q, rx_shift_q[DW-1:1]};
                    rx_cnt_d   = '0;
                    rx_per_d   = div_q;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + DW'(1);
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    if (sync2_q) begin
                        rx_done    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_fe_set  = 1'b1;
                        rx_state_d = RX_WAIT_HIGH;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + DW'(1);
                end
            end
            RX_WAIT_HIGH: begin
                if (sync2_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        rx_data_d   = rx_done ? rx_shift_q : rx_data_q;
        rx_valid_d  = rx_done ? 1'b1 : (rx_pop ? 1'b0 : rx_valid_q);
        rx_ovr_d    = (rx_ovr_q && !rd_status) || (rx_done && rx_valid_q && !rx_pop);
        frame_err_d = (frame_err_q && !rd_status) || rx_fe_set;
    end

    // ---------------- State registers ----------------
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            div_q       <= DIV_RESET;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_per_q    <= DIV_RESET;
            tx_bit_q    <= 3'd0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_drop_q   <= 1'b0;
            txd_q       <= 1'b1;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_per_q    <= DIV_RESET;
            rx_bit_q    <= 3'd0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_per_q    <= tx_per_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_drop_q   <= tx_drop_d;
            txd_q       <= txd_d;
            sync1_q     <= rxd;
            sync2_q     <= sync1_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_per_q    <= rx_per_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_ovr_q    <= rx_ovr_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Read mux is combinational so the CPU sees data in the same cycle
    logic [DW-1:0] status;

    assign status = {2'b00, tx_drop_q, (tx_state_q != TX_IDLE), frame_err_q,
                     rx_ovr_q, rx_valid_q, !hold_full_q};

    always_comb begin
        data_out = '0;
        if (rd_status) begin
            data_out = status;
        end else if (rd_rx) begin
            data_out = rx_data_q;
        end
    end

    assign data_oe = rd;
    assign txd     = txd_q;

endmodule

// File: tb/tb_io_uart_responder.sv
// Self-checking bench for io_uart_responder: frame-level reference model compared
// every cycle, plus directed literal checks of the key scenarios.
module tb_io_uart_responder;

    localparam logic [11:0] A_TX  = 12'hFF4;
    localparam logic [11:0] A_ST  = 12'hFF5;
    localparam logic [11:0] A_RX  = 12'hFF6;
    localparam logic [11:0] A_DIV = 12'hFF7;

    logic        clk = 1'b0;
    logic        rst_bar = 1'b0;
    logic [11:0] io_address = 12'h000;
    logic        cs_bar = 1'b1;
    logic        we_bar = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        rxd = 1'b1;
    logic        txd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    io_uart_responder #(.SUB_SEL(2'b01), .DIV_RESET(8'd16)) dut (
        .clk        (clk),
        .rst_bar    (rst_bar),
        .io_address (io_address),
        .cs_bar     (cs_bar),
        .we_bar     (we_bar),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .rxd        (rxd),
        .txd        (txd)
    );

    // Reference model: frames as bit vectors with per-bit countdowns
    logic       m_s1, m_s2;
    logic [7:0] m_div;
    logic       m_hold_full;
    logic [7:0] m_hold;
    logic       m_tx_active;
    logic [9:0] m_frame;
    int         m_tx_bits, m_tx_cyc;
    logic       m_txd, m_drop;
    int         m_rx_ph, m_rx_cyc, m_rx_n;
    logic [7:0] m_rx_byte, m_rx_data;
    logic       m_rx_valid, m_ovr, m_fe;

    logic rx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1; m_div = 8'd16;
        m_hold_full = 1'b0; m_hold = 8'h00;
        m_tx_active = 1'b0; m_frame = '1; m_tx_bits = 0; m_tx_cyc = 0;
        m_txd = 1'b1; m_drop = 1'b0;
        m_rx_ph = 0; m_rx_cyc = 0; m_rx_n = 0; m_rx_byte = 8'h00; m_rx_data = 8'h00;
        m_rx_valid = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    endtask

    function automatic logic [7:0] m_status();
        return {2'b00, m_drop, m_tx_active, m_fe, m_ovr, m_rx_valid, ~m_hold_full};
    endfunction

    task automatic start_frame();
        m_frame = {1'b1, m_hold, 1'b0};
        m_tx_bits = 10;
        m_tx_cyc = int'(m_div);
        m_tx_active = 1'b1;
        m_hold_full = 1'b0;
    endtask

    task automatic model_step();
        logic sel, wr, rd, rx_s, hold_pre, pop, clr, done, set_fe, set_drop, set_ovr, n_txd;
        logic [1:0] r;
        sel = (io_address[11:4] == 8'hFF) && (io_address[3:2] == 2'b01) && !cs_bar;
        wr = sel && !we_bar;
        rd = sel && we_bar;
        r = io_address[1:0];
        rx_s = m_s2;
        hold_pre = m_hold_full;
        n_txd = m_tx_active ? m_frame[0] : 1'b1;
        if (m_tx_active) begin
            m_tx_cyc--;
            if (m_tx_cyc == 0) begin
                m_frame = m_frame >> 1;
                m_tx_bits--;
                if (m_tx_bits == 0) begin
                    if (hold_pre) start_frame(); else m_tx_active = 1'b0;
                end else begin
                    m_tx_cyc = int'(m_div);
                end
            end
        end else if (hold_pre) begin
            start_frame();
        end
        set_drop = 1'b0;
        if (wr && r == 2'd0) begin
            if (hold_pre) set_drop = 1'b1;
            else begin m_hold = data_in; m_hold_full = 1'b1; end
        end
        done = 1'b0;
        set_fe = 1'b0;
        case (m_rx_ph)
            0: if (!rx_s) begin m_rx_ph = 1; m_rx_cyc = int'(m_div) / 2; end
            1: begin
                m_rx_cyc--;
                if (m_rx_cyc == 0) begin
                    if (rx_s) m_rx_ph = 0;
                    else begin m_rx_ph = 2; m_rx_n = 0; m_rx_cyc = int'(m_div); end
                end
            end
            2: begin
                m_rx_cyc--;
                if (m_rx_cyc == 0) begin
                    m_rx_byte[m_rx_n] = rx_s;
                    m_rx_n++;
                    m_rx_cyc = int'(m_div);
                    if (m_rx_n == 8) m_rx_ph = 3;
                end
            end
            3: begin
                m_rx_cyc--;
                if (m_rx_cyc == 0) begin
                    if (rx_s) begin done = 1'b1; m_rx_ph = 0; end
                    else begin set_fe = 1'b1; m_rx_ph = 4; end
                end
            end
            default: if (rx_s) m_rx_ph = 0;
        endcase
        pop = rd && (r == 2'd2) && m_rx_valid;
        clr = rd && (r == 2'd1);
        set_ovr = done && m_rx_valid && !pop;
        if (done) begin m_rx_data = m_rx_byte; m_rx_valid = 1'b1; end
        else if (pop) m_rx_valid = 1'b0;
        m_ovr  = (m_ovr && !clr) || set_ovr;
        m_fe   = (m_fe && !clr) || set_fe;
        m_drop = (m_drop && !clr) || set_drop;
        m_s2 = m_s1;
        m_s1 = rxd;
        if (wr && r == 2'd3) m_div = (data_in < 8'd2) ? 8'd2 : data_in;
        m_txd = n_txd;
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst_bar) model_reset(); else model_step();
    end

    // Per-cycle comparison of every output against the model
    initial forever begin
        logic sel, rd;
        logic [1:0] r;
        logic [7:0] exp_do;
        @(negedge clk);
        sel = (io_address[11:4] == 8'hFF) && (io_address[3:2] == 2'b01) && !cs_bar;
        rd = sel && we_bar;
        r = io_address[1:0];
        exp_do = 8'h00;
        if (rd && r == 2'd1) exp_do = m_status();
        else if (rd && r == 2'd2) exp_do = m_rx_data;
        check("model_txd", 32'(txd), 32'(m_txd));
        check("model_data_oe", 32'(data_oe), 32'(rd));
        check("model_data_out", 32'(data_out), 32'(exp_do));
    end

    // Serial line driver: one queued level per clock
    initial forever begin
        @(posedge clk);
        #1;
        if (rx_q.size() > 0) rxd = rx_q.pop_front();
        else rxd = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic idle_bus();
        io_address = 12'h000; cs_bar = 1'b1; we_bar = 1'b1; data_in = 8'h00;
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [7:0] d);
        io_address = a; cs_bar = 1'b0; we_bar = 1'b0; data_in = d;
        tick(1);
        idle_bus();
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [7:0] d, output logic oe);
        io_address = a; cs_bar = 1'b0; we_bar = 1'b1;
        #2;
        d = data_out;
        oe = data_oe;
        tick(1);
        idle_bus();
    endtask

    task automatic push_rx_frame(input logic [7:0] b, input logic stop, input int div);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++)
            for (int j = 0; j < div; j++) rx_q.push_back(f[k]);
    endtask

    task automatic wait_rx_drain();
        for (int i = 0; i < 3000 && rx_q.size() > 0; i++) tick(1);
        check("rx_drain_timeout", 32'(rx_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic oe;
        logic [9:0] exp_bits;
        int cur_div;
        model_reset();
        tick(3);
        rst_bar = 1'b1;
        tick(1);

        // Reset state and window decode
        bus_read(A_ST, d, oe);
        check("rst_status_oe", 32'(oe), 32'd1);
        check("rst_status", 32'(d), 32'h01);
        bus_read(12'hFF1, d, oe);
        check("offwin_oe", 32'(oe), 32'd0);
        check("offwin_data", 32'(d), 32'h00);

        // Single frame 0xA5, DIV = 4
        bus_write(A_DIV, 8'd4);
        bus_write(A_TX, 8'hA5);
        check("tx_pre_start", 32'(txd), 32'd1);
        tick(1);
        exp_bits = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            tick(k == 0 ? 1 : 4);
            check($sformatf("tx_a5_bit%0d", k), 32'(txd), 32'(exp_bits[k]));
        end
        bus_read(A_ST, d, oe);
        check("tx_busy_stop", 32'(d), 32'h11);
        tick(10);
        bus_read(A_ST, d, oe);
        check("tx_idle_status", 32'(d), 32'h01);

        // Holding-register chaining and drop
        bus_write(A_TX, 8'h01);
        tick(2);
        bus_write(A_TX, 8'h02);
        bus_write(A_TX, 8'h03);
        tick(45);
        bus_read(A_ST, d, oe);
        check("drop_status", 32'(d), 32'h31);
        bus_read(A_ST, d, oe);
        check("drop_cleared", 32'(d), 32'h11);
        tick(50);

        // RX single byte
        push_rx_frame(8'h3C, 1'b1, 4);
        wait_rx_drain();
        tick(6);
        bus_read(A_ST, d, oe);
        check("rx_valid_status", 32'(d), 32'h03);
        bus_read(A_RX, d, oe);
        check("rx_data_3c", 32'(d), 32'h3C);
        bus_read(A_ST, d, oe);
        check("rx_popped_status", 32'(d), 32'h01);

        // Overrun, then frame error preserving rx_valid
        push_rx_frame(8'h11, 1'b1, 4);
        push_rx_frame(8'h22, 1'b1, 4);
        wait_rx_drain();
        tick(6);
        bus_read(A_ST, d, oe);
        check("ovr_status", 32'(d), 32'h07);
        bus_read(A_RX, d, oe);
        check("ovr_data", 32'(d), 32'h22);
        push_rx_frame(8'h5A, 1'b1, 4);
        push_rx_frame(8'hC3, 1'b0, 4);
        wait_rx_drain();
        tick(6);
        bus_read(A_ST, d, oe);
        check("fe_status", 32'(d), 32'h0B);
        bus_read(A_RX, d, oe);
        check("fe_kept_data", 32'(d), 32'h5A);

        // Reset in the middle of TX and RX frames
        bus_write(A_TX, 8'h00);
        push_rx_frame(8'h00, 1'b1, 4);
        tick(14);
        check("tx_mid_low", 32'(txd), 32'd0);
        rst_bar = 1'b0;
        model_reset();
        rx_q.delete();
        #1;
        check("rst_txd_async", 32'(txd), 32'd1);
        tick(3);
        rst_bar = 1'b1;
        tick(2);
        bus_read(A_ST, d, oe);
        check("post_rst_status", 32'(d), 32'h01);
        bus_read(A_RX, d, oe);
        check("post_rst_rxdata", 32'(d), 32'h00);

        // One-cycle glitch on rxd
        bus_write(A_DIV, 8'd4);
        rx_q.push_back(1'b0);
        tick(12);
        bus_read(A_ST, d, oe);
        check("glitch_status", 32'(d), 32'h01);

        // Randomised traffic, checked by the per-cycle model comparison
        cur_div = 4;
        for (int it = 0; it < 250; it++) begin
            logic [11:0] a;
            int v;
            case ($urandom_range(0, 9))
                0, 1: bus_write(A_TX, 8'($urandom));
                2: if (rx_q.size() == 0)
                       push_rx_frame(8'($urandom), 1'($urandom_range(0, 5) != 0), cur_div);
                3: begin
                    v = $urandom_range(0, 6);
                    bus_write(A_DIV, 8'(v));
                    cur_div = (v < 2) ? 2 : v;
                end
                4, 5: bus_read({10'h3FD, 2'($urandom)}, d, oe);
                6: begin
                    a = 12'($urandom);
                    if (a[11:4] == 8'hFF) a[11:4] = 8'hFE;
                    bus_read(a, d, oe);
                end
                7: bus_write({10'h3FD, 1'b0, 1'($urandom)} | 12'h001, 8'($urandom));
                8: begin
                    io_address = A_TX; cs_bar = 1'b1; we_bar = 1'b0; data_in = 8'($urandom);
                    tick(1);
                    idle_bus();
                end
                default: tick(1);
            endcase
            tick($urandom_range(0, 12));
        end
        wait_rx_drain();
        tick(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_uart_responder.md
Name: io_uart_responder

Overview:
- Memory-mapped serial-port responder on the CPU I/O bus (io_address, csram_bar, weram_bar, databus).
- Answers CPU reads and writes in the I/O window io_address[11:4] = 8'hFF, sub-window io_address[3:2] = SUB_SEL.
- Serialises bytes written by the CPU onto txd and deserialises rxd into a byte the CPU reads.
- Format is 8N1 (8 data bits, no parity, 1 stop bit).
- Sits alongside odev0..2 and idev0 as the CPU's first handshaked peripheral.

Parameters:
- SUB_SEL, 2'b01: value of io_address[3:2] that selects this block.
- DIV_RESET, 8'd16: reset value of the bit-period divisor, in clk cycles per bit.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_bar  in  1  reset, asynchronous, active-low.
- io_address  in  12  CPU I/O address.
- cs_bar  in  1  bus chip select, active-low (the CPU's csram_bar).
- we_bar  in  1  write strobe, active-low (the CPU's weram_bar).
- data_in  in  8  CPU write data (databus).
- data_out  out  8  read data; 8'h00 whenever data_oe = 0.
- data_oe  out  1  high while this block must drive databus.
- rxd  in  1  serial receive line, asynchronous, idles high.
- txd  out  1  serial transmit line, idles high.

Behaviour:
- Decode:
  - sel = (io_address[11:4] == 8'hFF) & (io_address[3:2] == SUB_SEL) & !cs_bar.
  - reg = io_address[1:0].
  - wr = sel & !we_bar; rd = sel & we_bar.
- Register map:
  - 0 TXDATA: write only.
  - 1 STATUS: read only.
  - 2 RXDATA: read only.
  - 3 DIV: write only.
  - Reads of registers 0 and 3 return 8'h00. Writes to registers 1 and 2 are ignored.
- Reads:
  - data_oe = rd, combinational; data_out is combinational from the register state.
  - The side effect of a read (pop or clear) happens on the clock edge where rd holds.
- Writes: taken on every rising edge with wr high. The CPU holds wr for exactly one cycle.
- STATUS bits:
  - [0] tx_ready: holding register empty.
  - [1] rx_valid.
  - [2] rx_overrun, sticky.
  - [3] frame_err, sticky.
  - [4] tx_busy: TX FSM not IDLE.
  - [5] tx_drop, sticky.
  - [7:6] = 0.
  - A STATUS read clears bits 2, 3 and 5 at that edge. A set event in the same cycle wins, so the bit stays 1.
- DIV register:
  - 8-bit, reset to DIV_RESET. One bit period = DIV clk cycles.
  - Written values 0 and 1 are stored as 2.
  - A new value takes effect at the next bit boundary; the bit in progress is not cut short.
- TX path:
  - An 8-bit holding register and a shift register.
  - TXDATA write with holding empty: load holding, tx_ready goes 0 at that edge.
  - TXDATA write with holding full: data is dropped and tx_drop is set.
  - FSM states: IDLE, START, DATA, STOP.
  - IDLE with holding full: move holding to shift, go to START at the next edge, tx_ready returns to 1. txd falls 2 edges after the write edge.
  - START: txd = 0 for DIV cycles.
  - DATA: 8 bits, LSB first, DIV cycles each.
  - STOP: txd = 1 for DIV cycles.
  - At the end of STOP: if holding is full, go straight to START with no idle gap; otherwise go to IDLE.
- RX path:
  - rxd passes through a 2-flop synchroniser; both flops reset to 1.
  - FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when the synchronised line is 0, go to START.
  - START: wait DIV/2 cycles (floor), then sample. Sample 1 is a glitch: return to IDLE with no flag. Sample 0: go to DATA.
  - DATA: sample every DIV cycles, 8 bits, LSB first.
  - STOP: sample after DIV cycles.
    - Sample 1: load rx_data and set rx_valid. If rx_valid was already 1 and is not being popped in the same cycle, set rx_overrun; the new byte overwrites. Then go to IDLE.
    - Sample 0: set frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: go to IDLE once the synchronised line is 1.
  - RXDATA read: returns rx_data and clears rx_valid at that edge. If a new byte completes in the same edge, rx_valid stays 1 with the new data and no overrun is flagged.
  - RXDATA read with rx_valid = 0: returns the last rx_data and has no effect.
- Reset (asynchronous, any time, including mid-frame):
  - txd = 1; both FSMs IDLE.
  - Holding and rx_valid empty; all sticky flags 0.
  - DIV = DIV_RESET; rx_data = 8'h00; data_oe = 0.

Test Plan:
- Reset, then read STATUS at 12'hFF5 → data_oe = 1, data_out = 8'h01. An access at 12'hFF1 → data_oe = 0.
- DIV = 4; write 8'hA5 to TXDATA at edge N → txd low from N+2 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high. tx_busy = 1 throughout.
- DIV = 4; two back-to-back TXDATA writes 8'h01, 8'h02 followed by a third while holding is full → two contiguous frames with no gap, third byte dropped, STATUS = 8'h31 then 8'h11 after the STATUS read.
- DIV = 4; drive rxd with frame 8'h3C → rx_valid = 1. RXDATA read returns 8'h3C, after which STATUS[1] = 0.
- Send two RX frames with no read between them → STATUS = 8'h07 (tx_ready, rx_valid, rx_overrun) and RXDATA = second byte. Send a frame with stop bit 0 → frame_err = 1 and rx_valid unchanged.
- Assert rst_bar low mid-TX-frame and mid-RX-frame → txd = 1 immediately, STATUS = 8'h01 after release. A 1-cycle rxd low pulse → no byte and no flag.
